// File: rtl/wakeup_bcast_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wakeup_bcast_arbiter
// Brief    : Round-robin first-fit grant of FU PRN groups onto registered
//            ready-broadcast lanes. Optional WAKEUP_ARB_STATS_EN adds
//            saturating stall_cycles / grant_count counters.
// Revision : 1.0 - initial release
// ============================================================================
module wakeup_bcast_arbiter #(
    parameter int PRN_BITS     = 6,
    parameter int FU_COUNT     = 4,
    parameter int MAX_OPERANDS = 3,
    parameter int BCAST_SLOTS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_prn_valid [FU_COUNT][MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]         req_prn       [FU_COUNT][MAX_OPERANDS],
    output logic                        req_ready     [FU_COUNT],
    output logic                        bcast_valid   [BCAST_SLOTS],
    output logic [PRN_BITS-1:0]         bcast_prn     [BCAST_SLOTS],
    output logic [$clog2(FU_COUNT)-1:0] rr_ptr
`ifdef WAKEUP_ARB_STATS_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 grant_count
`endif
);

    localparam int c_PTR_W  = $clog2(FU_COUNT);
    localparam int c_SLOT_W = (BCAST_SLOTS > 1) ? $clog2(BCAST_SLOTS) : 1;
    localparam int c_SUM_W  = $clog2(BCAST_SLOTS + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_FU = c_PTR_W'(FU_COUNT - 1);

    generate
        if (BCAST_SLOTS < MAX_OPERANDS) begin : g_bad_slots
            $error("wakeup_bcast_arbiter: BCAST_SLOTS must be >= MAX_OPERANDS");
        end
        if (FU_COUNT < 2) begin : g_bad_fu_count
            $error("wakeup_bcast_arbiter: FU_COUNT must be >= 2");
        end
    endgenerate

    logic [FU_COUNT-1:0]    w_req;
    logic [FU_COUNT-1:0]    w_grant;
    int                     w_cnt        [FU_COUNT];
    logic [BCAST_SLOTS-1:0] w_lane_valid;
    logic [PRN_BITS-1:0]    w_lane_prn   [BCAST_SLOTS];
    logic [c_PTR_W-1:0]     w_ptr_next;
    logic [c_SUM_W-1:0]     w_grant_prns;

    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [BCAST_SLOTS-1:0] r_bcast_valid;
    logic [PRN_BITS-1:0]    r_bcast_prn  [BCAST_SLOTS];

    always_comb begin
        for (int f = 0; f < FU_COUNT; f++) begin
            w_cnt[f] = 0;
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (req_prn_valid[f][j]) begin
                    w_cnt[f] = w_cnt[f] + 1;
                end
            end
            w_req[f] = (w_cnt[f] != 0);
        end
    end

    // First-fit scan from rr_ptr: a group that does not fit is skipped, so a
    // smaller group further along may still use the leftover lanes.
    always_comb begin
        logic [c_PTR_W-1:0] v_idx;
        int                 v_rem;
        int                 v_fill;
        v_idx        = r_rr_ptr;
        v_rem        = BCAST_SLOTS;
        v_fill       = 0;
        w_grant      = '0;
        w_lane_valid = '0;
        w_ptr_next   = r_rr_ptr;
        for (int l = 0; l < BCAST_SLOTS; l++) begin
            w_lane_prn[l] = '0;
        end
        if (!rst) begin
            for (int k = 0; k < FU_COUNT; k++) begin
                if (w_req[v_idx] && (w_cnt[v_idx] <= v_rem)) begin
                    w_grant[v_idx] = 1'b1;
                    v_rem          = v_rem - w_cnt[v_idx];
                    w_ptr_next     = (v_idx == c_LAST_FU) ? '0 : v_idx + 1'b1;
                    for (int j = 0; j < MAX_OPERANDS; j++) begin
                        if (req_prn_valid[v_idx][j] && (v_fill < BCAST_SLOTS)) begin
                            w_lane_valid[c_SLOT_W'(v_fill)] = 1'b1;
                            w_lane_prn[c_SLOT_W'(v_fill)]   = req_prn[v_idx][j];
                            v_fill                          = v_fill + 1;
                        end
                    end
                end
                v_idx = (v_idx == c_LAST_FU) ? '0 : v_idx + 1'b1;
            end
        end
        w_grant_prns = c_SUM_W'(BCAST_SLOTS - v_rem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_bcast_valid <= '0;
            for (int l = 0; l < BCAST_SLOTS; l++) begin
                r_bcast_prn[l] <= '0;
            end
        end else begin
            r_rr_ptr      <= w_ptr_next;
            r_bcast_valid <= w_lane_valid;
            r_bcast_prn   <= w_lane_prn;
        end
    end

    generate
        for (genvar f = 0; f < FU_COUNT; f++) begin : g_ready
            assign req_ready[f] = w_grant[f];
        end
        for (genvar l = 0; l < BCAST_SLOTS; l++) begin : g_lane
            assign bcast_valid[l] = r_bcast_valid[l];
            assign bcast_prn[l]   = r_bcast_prn[l];
        end
    endgenerate

    assign rr_ptr = r_rr_ptr;

`ifdef WAKEUP_ARB_STATS_EN
    logic        w_stall;
    logic [32:0] w_gc_sum;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_grant_count;

    assign w_stall  = |(w_req & ~w_grant);
    assign w_gc_sum = {1'b0, r_grant_count} + 33'(w_grant_prns);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_grant_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            r_grant_count <= w_gc_sum[32] ? '1 : w_gc_sum[31:0];
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign grant_count  = r_grant_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wakeup_bcast_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wakeup_bcast_arbiter
// Brief    : Directed self-checking bench for wakeup_bcast_arbiter
//            (default parameters; stats checks when WAKEUP_ARB_STATS_EN set).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wakeup_bcast_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_prn_valid [4][3];
    logic [5:0] req_prn       [4][3];
    logic       req_ready     [4];
    logic       bcast_valid   [4];
    logic [5:0] bcast_prn     [4];
    logic [1:0] rr_ptr;
`ifdef WAKEUP_ARB_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] grant_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  ready_vec;
    logic [3:0]  bvalid_vec;
    logic [23:0] bprn_vec;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ready_vec[i]        = req_ready[i];
            bvalid_vec[i]       = bcast_valid[i];
            bprn_vec[i*6 +: 6]  = bcast_prn[i];
        end
    end

    wakeup_bcast_arbiter #(
        .PRN_BITS    (6),
        .FU_COUNT    (4),
        .MAX_OPERANDS(3),
        .BCAST_SLOTS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_prn_valid(req_prn_valid),
        .req_prn      (req_prn),
        .req_ready    (req_ready),
        .bcast_valid  (bcast_valid),
        .bcast_prn    (bcast_prn),
        .rr_ptr       (rr_ptr)
`ifdef WAKEUP_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .grant_count  (grant_count)
`endif
    );

    task automatic clear_reqs();
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 3; j++) begin
                req_prn_valid[f][j] = 1'b0;
                req_prn[f][j]       = 6'd0;
            end
        end
    endtask

    task automatic set_req(input int f, input logic [2:0] v,
                           input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
        req_prn_valid[f][0] = v[0];
        req_prn_valid[f][1] = v[1];
        req_prn_valid[f][2] = v[2];
        req_prn[f][0] = p0;
        req_prn[f][1] = p1;
        req_prn[f][2] = p2;
    endtask

    task automatic set_all_full();
        for (int f = 0; f < 4; f++) begin
            set_req(f, 3'b111, 6'(f*10+1), 6'(f*10+2), 6'(f*10+3));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        set_all_full();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr got %0d exp 0", rr_ptr); end
        n_tests++; if (bvalid_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_bvalid got %b exp 0000", bvalid_vec); end
        n_tests++; if (bprn_vec !== 24'd0) begin n_fail++; $display("FAIL reset_bprn got %h exp 000000", bprn_vec); end
        n_tests++; if (ready_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", ready_vec); end
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
    endtask

    task automatic test_single();
        set_req(2, 3'b011, 6'd5, 6'd7, 6'd63);
        #1;
        n_tests++; if (ready_vec !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b0011) begin n_fail++; $display("FAIL single_bvalid got %b exp 0011", bvalid_vec); end
        n_tests++; if (bprn_vec !== {6'd0, 6'd0, 6'd7, 6'd5}) begin n_fail++; $display("FAIL single_bprn got %h exp %h", bprn_vec, {6'd0, 6'd0, 6'd7, 6'd5}); end
        n_tests++; if (rr_ptr !== 2'd3) begin n_fail++; $display("FAIL single_rr_ptr got %0d exp 3", rr_ptr); end
        @(negedge clk);
        clear_reqs();
        #1;
        n_tests++; if (ready_vec !== 4'b0000) begin n_fail++; $display("FAIL idle_ready got %b exp 0000", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b0000) begin n_fail++; $display("FAIL idle_bvalid got %b exp 0000", bvalid_vec); end
        n_tests++; if (rr_ptr !== 2'd3) begin n_fail++; $display("FAIL idle_rr_ptr got %0d exp 3", rr_ptr); end
    endtask

    task automatic test_overflow_skip();
        @(negedge clk);
        set_req(3, 3'b001, 6'd1, 6'd0, 6'd0);
        @(posedge clk); #1;
        n_tests++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_rr_ptr got %0d exp 0", rr_ptr); end
        @(negedge clk);
        clear_reqs();
        set_req(0, 3'b111, 6'd10, 6'd11, 6'd12);
        set_req(1, 3'b011, 6'd13, 6'd14, 6'd63);
        set_req(2, 3'b001, 6'd20, 6'd63, 6'd63);
        #1;
        n_tests++; if (ready_vec !== 4'b0101) begin n_fail++; $display("FAIL overflow_ready got %b exp 0101", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b1111) begin n_fail++; $display("FAIL overflow_bvalid got %b exp 1111", bvalid_vec); end
        n_tests++; if (bprn_vec !== {6'd20, 6'd12, 6'd11, 6'd10}) begin n_fail++; $display("FAIL overflow_bprn got %h exp %h", bprn_vec, {6'd20, 6'd12, 6'd11, 6'd10}); end
        n_tests++; if (rr_ptr !== 2'd3) begin n_fail++; $display("FAIL overflow_rr_ptr got %0d exp 3", rr_ptr); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_starvation();
        set_req(3, 3'b001, 6'd1, 6'd0, 6'd0);
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            int f;
            f = c % 4;
            @(negedge clk);
            if (c == 0) begin
                clear_reqs();
                set_all_full();
            end
            #1;
            n_tests++; if (ready_vec !== 4'(1 << f)) begin n_fail++; $display("FAIL starve_ready c%0d got %b exp %b", c, ready_vec, 4'(1 << f)); end
            @(posedge clk); #1;
            n_tests++; if (bprn_vec !== {6'd0, 6'(f*10+3), 6'(f*10+2), 6'(f*10+1)} || bvalid_vec !== 4'b0111) begin
                n_fail++; $display("FAIL starve_lanes c%0d got %h/%b exp %h/0111", c, bprn_vec, bvalid_vec, {6'd0, 6'(f*10+3), 6'(f*10+2), 6'(f*10+1)});
            end
            n_tests++; if (rr_ptr !== 2'((f+1) % 4)) begin n_fail++; $display("FAIL starve_rr_ptr c%0d got %0d exp %0d", c, rr_ptr, (f+1) % 4); end
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_sparse();
        set_req(1, 3'b100, 6'd63, 6'd63, 6'd33);
        set_req(3, 3'b101, 6'd40, 6'd63, 6'd41);
        #1;
        n_tests++; if (ready_vec !== 4'b1010) begin n_fail++; $display("FAIL sparse_ready got %b exp 1010", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b0111) begin n_fail++; $display("FAIL sparse_bvalid got %b exp 0111", bvalid_vec); end
        n_tests++; if (bprn_vec !== {6'd0, 6'd41, 6'd40, 6'd33}) begin n_fail++; $display("FAIL sparse_bprn got %h exp %h", bprn_vec, {6'd0, 6'd41, 6'd40, 6'd33}); end
        n_tests++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL sparse_rr_ptr got %0d exp 0", rr_ptr); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reset_mid_burst();
        set_all_full();
        #1;
        n_tests++; if (ready_vec !== 4'b0001) begin n_fail++; $display("FAIL burst_ready got %b exp 0001", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (rr_ptr !== 2'd1) begin n_fail++; $display("FAIL burst_rr_ptr got %0d exp 1", rr_ptr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (ready_vec !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready got %b exp 0000", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b0000 || bprn_vec !== 24'd0) begin n_fail++; $display("FAIL midrst_lanes got %h/%b exp 000000/0000", bprn_vec, bvalid_vec); end
        n_tests++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL midrst_rr_ptr got %0d exp 0", rr_ptr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (ready_vec !== 4'b0001) begin n_fail++; $display("FAIL postrst_ready got %b exp 0001", ready_vec); end
        @(posedge clk); #1;
        n_tests++; if (bvalid_vec !== 4'b0111 || bprn_vec !== {6'd0, 6'd3, 6'd2, 6'd1}) begin
            n_fail++; $display("FAIL postrst_lanes got %h/%b exp %h/0111", bprn_vec, bvalid_vec, {6'd0, 6'd3, 6'd2, 6'd1});
        end
        n_tests++; if (rr_ptr !== 2'd1) begin n_fail++; $display("FAIL postrst_rr_ptr got %0d exp 1", rr_ptr); end
        @(negedge clk);
        clear_reqs();
    endtask

`ifdef WAKEUP_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (stall_cycles !== 32'd0 || grant_count !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d/%0d exp 0/0", stall_cycles, grant_count); end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 3'b111, 6'd10, 6'd11, 6'd12);
        set_req(1, 3'b011, 6'd13, 6'd14, 6'd63);
        set_req(2, 3'b001, 6'd20, 6'd63, 6'd63);
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL stats_stall got %0d exp 5", stall_cycles); end
        n_tests++; if (grant_count !== 32'd20) begin n_fail++; $display("FAIL stats_grant got %0d exp 20", grant_count); end
        @(negedge clk);
        clear_reqs();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow_skip();
        test_starvation();
        test_sparse();
        test_reset_mid_burst();
`ifdef WAKEUP_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
